// File: rtl/alu_arith_pkg.sv
// ---------------------------------------------------------------------------
// alu_arith_pkg
// Constants shared by the iterative arithmetic units of the eBPF ALU
// (shift-add multiplier and iterative divider).
//   DATA_WIDTH : default operand width in bits
//   CNT_W      : width of an iteration counter that can hold DATA_WIDTH
//   data_t     : operand vector type
// ---------------------------------------------------------------------------
package alu_arith_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/mul_step.sv
// ---------------------------------------------------------------------------
// mul_step
// One radix-2 shift-add iteration, purely combinational. Kept as its own
// module so the adder/shift datapath can be checked in isolation.
// Ports:
//   hi, lo           : current accumulator halves {hi, lo}
//   mcand            : registered multiplicand
//   next_hi, next_lo : accumulator after this iteration
// ---------------------------------------------------------------------------
module mul_step #(
    parameter int data_width = 64
) (
    input  logic [data_width-1:0] hi,
    input  logic [data_width-1:0] lo,
    input  logic [data_width-1:0] mcand,
    output logic [data_width-1:0] next_hi,
    output logic [data_width-1:0] next_lo
);

    logic [data_width:0] sum;

    always_comb begin
        // The extra sum bit keeps the carry; it lands in the MSB of hi
        // once the whole accumulator shifts right by one.
        sum = {1'b0, hi} + {1'b0, mcand & {data_width{lo[0]}}};
        {next_hi, next_lo} = {sum, lo[data_width-1:1]};
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
// Iterative radix-2 unsigned multiplier producing a 2*data_width product,
// consuming one multiplier bit per clock.
//
// Handshake: a one-cycle stb with valid operands is always accepted, idle or
// busy (an in-flight operation is dropped). ack is low from the cycle after
// stb until the product is complete; while ack is high the product and ovf
// are valid and held until the next stb. No back-pressure exists.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous active-high reset (priority over stb)
//   multiplicand : operand A, sampled on stb
//   multiplier   : operand B, sampled on stb
//   stb          : start pulse
//   product_lo   : product bits [data_width-1:0]
//   product_hi   : product bits [2*data_width-1:data_width]
//   ack          : idle / result valid
//   ovf          : product_hi non-zero, qualified by ack
//
// Build option: SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN finishes as soon as the
// remaining multiplier bits are all zero, by shifting the accumulator right
// by the remaining count in a single cycle.
// ---------------------------------------------------------------------------
module shift_add_multiplier
    import alu_arith_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] multiplicand,
    input  logic [data_width-1:0] multiplier,
    input  logic                  stb,
    output logic [data_width-1:0] product_lo,
    output logic [data_width-1:0] product_hi,
    output logic                  ack,
    output logic                  ovf
);

    localparam int cnt_w = $clog2(data_width + 1);

    logic [2*data_width-1:0] acc;
    logic [2*data_width-1:0] acc_next;
    logic [data_width-1:0]   mcand_r;
    logic [data_width-1:0]   step_hi;
    logic [data_width-1:0]   step_lo;
    logic [cnt_w-1:0]        counter;
    logic [cnt_w-1:0]        counter_next;

    mul_step #(
        .data_width(data_width)
    ) u_step (
        .hi      (acc[2*data_width-1:data_width]),
        .lo      (acc[data_width-1:0]),
        .mcand   (mcand_r),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    // The unconsumed multiplier bits are lo[counter-1:0]; shifting them to
    // the top of the word discards the already-consumed product bits above.
    logic [data_width-1:0] unconsumed;
    always_comb begin
        unconsumed = acc[data_width-1:0] << (cnt_w'(data_width) - counter);
    end
`endif

    always_comb begin
        acc_next     = acc;
        counter_next = counter;
        if (counter != '0) begin
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
            if (unconsumed == '0) begin
                // Remaining iterations would add nothing, only shift.
                acc_next     = acc >> counter;
                counter_next = '0;
            end else begin
                acc_next     = {step_hi, step_lo};
                counter_next = counter - 1'b1;
            end
`else
            acc_next     = {step_hi, step_lo};
            counter_next = counter - 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand_r <= '0;
            counter <= '0;
        end else if (stb) begin
            acc     <= {{data_width{1'b0}}, multiplier};
            mcand_r <= multiplicand;
            counter <= cnt_w'(data_width);
        end else begin
            acc     <= acc_next;
            counter <= counter_next;
        end
    end

    assign ack        = (counter == '0);
    assign product_lo = acc[data_width-1:0];
    assign product_hi = acc[2*data_width-1:data_width];
    assign ovf        = (|product_hi) && ack;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
// Bench for shift_add_multiplier at the default 64-bit width. Expected
// products come from plain 128-bit multiplication; expected latency comes
// from the multiplier value (fixed width, or highest set bit with early exit).
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         stb;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic [W-1:0] product_lo;
    logic [W-1:0] product_hi;
    logic         ack;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    shift_add_multiplier dut (
        .clk          (clk),
        .reset        (reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .stb          (stb),
        .product_lo   (product_lo),
        .product_hi   (product_hi),
        .ack          (ack),
        .ovf          (ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
        int h;
        h = -1;
        for (int i = 0; i < W; i++) if (b[i]) h = i;
        return (h + 2 > W) ? W : h + 2;
`else
        return W;
`endif
    endfunction

    function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Inputs change and outputs are sampled on the falling edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        multiplicand = a;
        multiplier   = b;
        stb          = 1'b1;
        @(negedge clk);
        stb          = 1'b0;
    endtask

    // Counts rising edges after the capturing edge until ack; bounded.
    task automatic wait_ack(output int lat);
        lat = 0;
        while (!ack && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] b,
                                input logic [2*W-1:0] exp_p, input int lat);
        chk({name, " latency"}, 128'(lat), 128'(exp_lat(b)));
        chk({name, " product"}, {product_hi, product_lo}, exp_p);
        chk({name, " ovf"}, 128'(ovf), 128'(exp_p[2*W-1:W] != '0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int hold_bad;
        logic [2*W-1:0] exp_p;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 64'd3, b: 64'd5, hi: 64'd0, lo: 64'd15, ovf: 1'b0};
        vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF,
                    hi: 64'hFFFF_FFFF_FFFF_FFFE, lo: 64'd1, ovf: 1'b1};
        vecs[2] = '{a: 64'd0, b: 64'd0, hi: 64'd0, lo: 64'd0, ovf: 1'b0};
        vecs[3] = '{a: 64'h1_0000_0000, b: 64'h1_0000_0000, hi: 64'd1, lo: 64'd0, ovf: 1'b1};
        vecs[4] = '{a: 64'hDEAD, b: 64'd1, hi: 64'd0, lo: 64'hDEAD, ovf: 1'b0};
        vecs[5] = '{a: 64'hDEAD, b: 64'd0, hi: 64'd0, lo: 64'd0, ovf: 1'b0};
        vecs[6] = '{a: 64'h8000_0000_0000_0000, b: 64'd2, hi: 64'd1, lo: 64'd0, ovf: 1'b1};
        vecs[7] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1,
                    hi: 64'd0, lo: 64'hFFFF_FFFF_FFFF_FFFF, ovf: 1'b0};

        // reset then idle
        reset        = 1'b1;
        stb          = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset ack", 128'(ack), 128'(1));
        chk("reset product", {product_hi, product_lo}, '0);
        chk("reset ovf", 128'(ovf), 128'(0));

        // table vectors, each followed by a 10-cycle hold check
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            if (exp_lat(vecs[i].b) > 1) chk($sformatf("vec%0d busy", i), 128'(ack), 128'(0));
            wait_ack(lat);
            chk($sformatf("vec%0d latency", i), 128'(lat), 128'(exp_lat(vecs[i].b)));
            chk($sformatf("vec%0d hi", i), 128'(product_hi), 128'(vecs[i].hi));
            chk($sformatf("vec%0d lo", i), 128'(product_lo), 128'(vecs[i].lo));
            chk($sformatf("vec%0d ovf", i), 128'(ovf), 128'(vecs[i].ovf));
            hold_bad = 0;
            repeat (10) begin
                @(negedge clk);
                if (!ack || product_hi !== vecs[i].hi || product_lo !== vecs[i].lo) hold_bad++;
            end
            chk($sformatf("vec%0d hold", i), 128'(hold_bad), 128'(0));
        end

        // restart mid-operation abandons the first multiply
        start_op(64'd7, 64'd9);
        repeat (19) @(negedge clk);
        start_op(64'h1_0000_0000, 64'h1_0000_0000);
        wait_ack(lat);
        check_result("abandon", 64'h1_0000_0000, 128'(1) << 64, lat);

        // reset mid-operation
        start_op(64'd100, 64'd200);
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset ack", 128'(ack), 128'(1));
        chk("midreset product", {product_hi, product_lo}, '0);
        chk("midreset ovf", 128'(ovf), 128'(0));
        reset = 1'b0;
        start_op(64'd2, 64'd2);
        wait_ack(lat);
        check_result("after reset", 64'd2, 128'd4, lat);

        // random vectors with varied multiplier widths
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rb = rb >> $urandom_range(0, W);
            if ($urandom_range(0, 7) == 0) ra = ra >> $urandom_range(0, W);
            exp_q.push_back(model_mul(ra, rb));
            start_op(ra, rb);
            wait_ack(lat);
            exp_p = exp_q.pop_front();
            check_result($sformatf("rand%0d", n), rb, exp_p, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
